// File: rtl/sprite_pkg.sv
// Shared constants and state type for the sprite ROM arbiter.
package sprite_pkg;

    localparam int unsigned SPRITE_ROM_DEPTH = 128;
    localparam int unsigned SPRITE_ADDR_W    = 7;
    localparam int unsigned SPRITE_DATA_W    = 16;
    localparam int unsigned SPRITE_LEN_W     = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick; search begins one past last_winner.
module rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_winner,
    output logic [NREQ-1:0]  grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int unsigned      cand;
    logic [IDX_W-1:0] cidx;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        cand         = 0;
        cidx         = '0;
        // i runs 1..NREQ so last_winner itself is examined last
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = (32'(last_winner) + i) % NREQ;
            cidx = IDX_W'(cand);
            if (!any && req[cidx]) begin
                any                = 1'b1;
                grant_idx          = cidx;
                grant_onehot[cidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one registered-address sprite ROM among NREQ renderers using
// round-robin arbitration and fixed-length bursts of consecutive words.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADDR_W = SPRITE_ADDR_W,
    parameter int unsigned DATA_W = SPRITE_DATA_W,
    parameter int unsigned LEN_W  = SPRITE_LEN_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_last,
    output logic                     busy,
    output logic [ADDR_W-1:0]        rom_address,
    output logic                     rom_clken,
    input  logic [DATA_W-1:0]        rom_readdata
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NREQ - 1);

    arb_state_t        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] hold_addr;
    logic [LEN_W-1:0]  remaining;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  last_winner;
    logic              first_q;

    logic              issue_d;
    logic              is_last_d;
    logic [IDX_W-1:0]  owner_d;

    logic [NREQ-1:0]   grant_onehot;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req          (req),
        .last_winner  (last_winner),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (grant_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_onehot[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_len  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB_IDLE;
            cur_addr    <= '0;
            hold_addr   <= '0;
            remaining   <= '0;
            owner       <= '0;
            last_winner <= LAST_INIT;
            first_q     <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    first_q <= 1'b0;
                    if (grant_any) begin
                        cur_addr    <= sel_addr;
                        remaining   <= sel_len;
                        owner       <= grant_idx;
                        last_winner <= grant_idx;
                        first_q     <= 1'b1;
                        state       <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    first_q   <= 1'b0;
                    hold_addr <= cur_addr;
                    cur_addr  <= cur_addr + 1'b1;
                    if (remaining == '0) begin
                        state <= ARB_IDLE;
                    end else begin
                        remaining <= remaining - 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // ROM output lags the issued address by one cycle; tag it to match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_d   <= 1'b0;
            is_last_d <= 1'b0;
            owner_d   <= '0;
        end else begin
            issue_d   <= (state == ARB_BURST);
            is_last_d <= (remaining == '0);
            owner_d   <= owner;
        end
    end

    always_comb begin
        ack       = '0;
        rsp_valid = '0;
        if (first_q) begin
            ack[owner] = 1'b1;
        end
        if (issue_d) begin
            rsp_valid[owner_d] = 1'b1;
        end
    end

    assign rsp_data    = rom_readdata;
    assign rsp_last    = is_last_d & issue_d;
    assign busy        = (state != ARB_IDLE) | issue_d;
    assign rom_clken   = (state == ARB_BURST);
    assign rom_address = (state == ARB_BURST) ? cur_addr : hold_addr;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a behavioural registered-address ROM.
module tb_sprite_rom_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic                   rsp_last;
    logic                   busy;
    logic [ADDR_W-1:0]      rom_address;
    logic                   rom_clken;
    logic [DATA_W-1:0]      rom_readdata;
    logic [DATA_W-1:0]      rom_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return {a, 2'b01, a};
    endfunction

    always @(posedge clk) begin
        if (rom_clken) rom_q <= rom_word(rom_address);
    end
    assign rom_readdata = rom_q;

    sprite_rom_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .ack          (ack),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_last     (rsp_last),
        .busy         (busy),
        .rom_address  (rom_address),
        .rom_clken    (rom_clken),
        .rom_readdata (rom_readdata)
    );

    task automatic test_reset();
        reset = 1'b1; req = '0; req_addr = '0; req_len = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ack, rsp_valid, rsp_last, busy, rom_clken} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b valid=%b last=%b busy=%b clken=%b want all 0",
                     ack, rsp_valid, rsp_last, busy, rom_clken);
        end
        checks++;
        if (rom_address !== 7'd0) begin
            errors++;
            $display("FAIL reset_address got %0d want 0", rom_address);
        end
        reset = 1'b0;
    endtask

    // single, wrap-around and maximum-length bursts from an idle arbiter
    task automatic test_bursts();
        int unsigned vid [3]  = '{0, 2, 3};
        int unsigned vadr [3] = '{5, 126, 0};
        int unsigned vlen [3] = '{2, 3, 15};
        for (int v = 0; v < 3; v++) begin
            int unsigned   len_words;
            int            nvalid;
            logic [NREQ-1:0]   oh;
            logic [ADDR_W-1:0] exp_addr;
            logic [NREQ-1:0]   exp_ack, exp_valid;
            len_words = vlen[v] + 1;
            nvalid = 0;
            oh = 4'b0001 << vid[v];
            @(negedge clk);
            req = oh; req_addr = '0; req_len = '0;
            req_addr[vid[v]*ADDR_W +: ADDR_W] = 7'(vadr[v]);
            req_len[vid[v]*LEN_W +: LEN_W]    = 4'(vlen[v]);
            for (int unsigned k = 1; k <= len_words + 2; k++) begin
                @(negedge clk);
                exp_addr  = 7'(vadr[v] + ((k <= len_words) ? k - 1 : len_words - 1));
                exp_ack   = (k == 1) ? oh : '0;
                exp_valid = (k >= 2 && k <= len_words + 1) ? oh : '0;
                checks++;
                if (ack !== exp_ack) begin
                    errors++;
                    $display("FAIL burst%0d_ack k=%0d got %b want %b", v, k, ack, exp_ack);
                end
                checks++;
                if (rom_clken !== (k <= len_words) || rom_address !== exp_addr) begin
                    errors++;
                    $display("FAIL burst%0d_addr k=%0d got clken=%b addr=%0d want clken=%b addr=%0d",
                             v, k, rom_clken, rom_address, (k <= len_words), exp_addr);
                end
                checks++;
                if (rsp_valid !== exp_valid || rsp_last !== (k == len_words + 1)) begin
                    errors++;
                    $display("FAIL burst%0d_valid k=%0d got valid=%b last=%b want valid=%b last=%b",
                             v, k, rsp_valid, rsp_last, exp_valid, (k == len_words + 1));
                end
                if (exp_valid != '0) begin
                    nvalid++;
                    checks++;
                    if (rsp_data !== rom_word(7'(vadr[v] + k - 2))) begin
                        errors++;
                        $display("FAIL burst%0d_data k=%0d got %h want %h",
                                 v, k, rsp_data, rom_word(7'(vadr[v] + k - 2)));
                    end
                end
                checks++;
                if (busy !== (k <= len_words + 1)) begin
                    errors++;
                    $display("FAIL burst%0d_busy k=%0d got %b want %b", v, k, busy, (k <= len_words + 1));
                end
                if (k == 1) req = '0;
            end
            checks++;
            if (nvalid != int'(len_words)) begin
                errors++;
                $display("FAIL burst%0d_count got %0d want %0d", v, nvalid, len_words);
            end
        end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] exp_ack, exp_valid;
        int unsigned     widx;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req = 4'b1111; req_len = '0;
        for (int unsigned i = 0; i < NREQ; i++) req_addr[i*ADDR_W +: ADDR_W] = 7'(10 * i);
        for (int unsigned k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_ack   = (k % 2 == 1 && k <= 7) ? (4'b0001 << ((k - 1) / 2)) : '0;
            exp_valid = (k % 2 == 0 && k <= 8) ? (4'b0001 << ((k - 2) / 2)) : '0;
            checks++;
            if (ack !== exp_ack) begin
                errors++;
                $display("FAIL contention_ack k=%0d got %b want %b", k, ack, exp_ack);
            end
            checks++;
            if (rsp_valid !== exp_valid || rsp_last !== (exp_valid != '0)) begin
                errors++;
                $display("FAIL contention_valid k=%0d got valid=%b last=%b want valid=%b last=%b",
                         k, rsp_valid, rsp_last, exp_valid, (exp_valid != '0));
            end
            if (exp_valid != '0) begin
                widx = (k - 2) / 2;
                checks++;
                if (rsp_data !== rom_word(7'(10 * widx))) begin
                    errors++;
                    $display("FAIL contention_data k=%0d got %h want %h", k, rsp_data, rom_word(7'(10 * widx)));
                end
            end
            req = req & ~ack;
        end
        req = '0;
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] exp_ack;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_addr = '0; req_len = '0;
        req_addr[1*ADDR_W +: ADDR_W] = 7'd30; req_len[1*LEN_W +: LEN_W] = 4'd1;
        req_addr[3*ADDR_W +: ADDR_W] = 7'd60; req_len[3*LEN_W +: LEN_W] = 4'd1;
        req = 4'b1010;
        for (int unsigned k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_ack = (k % 3 == 1) ? (((k / 3) % 2 == 0) ? 4'b0010 : 4'b1000) : '0;
            checks++;
            if (ack !== exp_ack) begin
                errors++;
                $display("FAIL fairness_ack k=%0d got %b want %b", k, ack, exp_ack);
            end
        end
        req = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fairness_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        req_addr = '0; req_len = '0;
        req_addr[1*ADDR_W +: ADDR_W] = 7'd20; req_len[1*LEN_W +: LEN_W] = 4'd15;
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_ack got %b want 0010", ack);
        end
        req = '0;
        repeat (4) @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_data !== rom_word(7'd23)) begin
            errors++;
            $display("FAIL midrst_pre got valid=%b data=%h want 0010 %h", rsp_valid, rsp_data, rom_word(7'd23));
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({ack, rsp_valid, rsp_last, busy, rom_clken} !== '0 || rom_address !== 7'd0) begin
            errors++;
            $display("FAIL midrst_async got ack=%b valid=%b last=%b busy=%b clken=%b addr=%0d want all 0",
                     ack, rsp_valid, rsp_last, busy, rom_clken, rom_address);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 1) reset = 1'b0;
            checks++;
            if (rsp_valid !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet k=%0d got valid=%b busy=%b want 0 0", k, rsp_valid, busy);
            end
        end
        req_addr[1*ADDR_W +: ADDR_W] = 7'd40; req_len[1*LEN_W +: LEN_W] = 4'd1;
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010 || rom_address !== 7'd40 || rom_clken !== 1'b1) begin
            errors++;
            $display("FAIL midrst_regrant got ack=%b addr=%0d clken=%b want 0010 40 1", ack, rom_address, rom_clken);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_data !== rom_word(7'd40) || rsp_last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_word0 got valid=%b data=%h last=%b want 0010 %h 0",
                     rsp_valid, rsp_data, rsp_last, rom_word(7'd40));
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_data !== rom_word(7'd41) || rsp_last !== 1'b1) begin
            errors++;
            $display("FAIL midrst_word1 got valid=%b data=%h last=%b want 0010 %h 1",
                     rsp_valid, rsp_data, rsp_last, rom_word(7'd41));
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_done got valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_bursts();
        test_contention();
        test_fairness();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
